// File: rtl/lab_logic_pipe_pkg.sv
// Shared types and width helpers for the lab logic pipeline.
package lab_logic_pkg;

  typedef enum logic [1:0] {
    MODE_GATE = 2'b00,
    MODE_SUM  = 2'b01,
    MODE_ADD  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  // Bits needed to hold a popcount of a w-bit vector (0..w inclusive).
  function automatic int ones_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ONES_W = ones_w(DEF_WIDTH);

endpackage

// File: rtl/lab_logic_pipe_if.sv
// Operand/result bus for lab_logic_pipe. master = source/sink side, slave = pipe.
interface lab_logic_pipe_if
  import lab_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();
  localparam int OW = ones_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  mode_e            mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [OW-1:0]    x_ones;
  logic             cnt_clr;
  logic [CNT_W-1:0] result_count;

  modport master (
    output in_valid, a, b, c, mode, out_ready, cnt_clr,
    input  in_ready, out_valid, x, y, x_ones, result_count
  );

  modport slave (
    input  in_valid, a, b, c, mode, out_ready, cnt_clr,
    output in_ready, out_valid, x, y, x_ones, result_count
  );
endinterface

// File: rtl/lab_pipe_slice.sv
// One-entry valid/ready register slice; ready passes through combinationally
// so a full slice can load and drain on the same edge.
module lab_pipe_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  assign in_ready = ~out_valid | out_ready;

  // Load on accept, empty on drain, otherwise hold contents stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lab_logic_pipe.sv
// Two-stage pipelined per-bit logic/arithmetic unit with popcount of x
// and a saturating count of delivered results.
module lab_logic_pipe
  import lab_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  lab_logic_pipe_if.slave bus
);

  localparam int OW   = ones_w(WIDTH);
  localparam int S1_W = 3 * WIDTH + 2;
  localparam int S2_W = 2 * WIDTH + OW;

  logic             s1_in_ready;
  logic             s1_valid;
  logic [S1_W-1:0]  s1_data;
  logic             s2_in_ready;
  logic             s2_valid;
  logic [S2_W-1:0]  s2_data;

  mode_e            s1_mode;
  logic [WIDTH-1:0] s1_a, s1_b, s1_c;
  logic [WIDTH-1:0] x_n, y_n;
  logic [OW-1:0]    ones_n;
  logic [WIDTH:0]   add_sum;
  logic [CNT_W-1:0] count;

  // Stage 1: operands and mode captured together.
  lab_pipe_slice #(.DW(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (s1_in_ready),
    .in_data   ({logic'(1'b0) ? 2'b00 : 2'(bus.mode), bus.a, bus.b, bus.c}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign s1_mode = mode_e'(s1_data[S1_W-1 -: 2]);
  assign s1_a    = s1_data[3*WIDTH-1 -: WIDTH];
  assign s1_b    = s1_data[2*WIDTH-1 -: WIDTH];
  assign s1_c    = s1_data[WIDTH-1:0];

  // Carry-in is only the low bit of c; upper c bits play no part in ADD.
  assign add_sum = {1'b0, s1_a} + {1'b0, s1_b} + (WIDTH+1)'(s1_c[0]);

  // Function datapath between the two slices.
  always_comb begin
    x_n = '0;
    y_n = '0;
    case (s1_mode)
      MODE_GATE: begin
        x_n = ~s1_c ^ (s1_a | s1_b);
        y_n = s1_a & s1_b;
      end
      MODE_SUM: begin
        x_n = s1_a ^ s1_b ^ s1_c;
        y_n = (s1_a & s1_b) | (s1_a & s1_c) | (s1_b & s1_c);
      end
      MODE_ADD: begin
        x_n = add_sum[WIDTH-1:0];
        y_n = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
      end
      MODE_PASS: begin
        x_n = s1_a;
        y_n = s1_b;
      end
      default: begin
        x_n = '0;
        y_n = '0;
      end
    endcase
  end

  // Popcount of the x result, registered alongside it in stage 2.
  always_comb begin
    ones_n = '0;
    for (int i = 0; i < WIDTH; i++) ones_n = ones_n + OW'(x_n[i]);
  end

  // Stage 2: results as presented to the sink.
  lab_pipe_slice #(.DW(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   ({x_n, y_n, ones_n}),
    .out_valid (s2_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_data)
  );

  // Saturating delivered-result counter; clear beats a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      count <= '0;
    end else if (s2_valid && bus.out_ready && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  // Nothing is accepted while reset is asserted.
  assign bus.in_ready     = s1_in_ready & ~rst;
  assign bus.out_valid    = s2_valid;
  assign bus.x            = s2_data[S2_W-1 -: WIDTH];
  assign bus.y            = s2_data[WIDTH+OW-1 -: WIDTH];
  assign bus.x_ones       = s2_data[OW-1:0];
  assign bus.result_count = count;

endmodule

// File: tb/tb_lab_logic_pipe.sv
// Scoreboard bench for lab_logic_pipe: driver pushes expected results,
// negedge monitor pops and compares on every output transfer.
module tb_lab_logic_pipe;
  import lab_logic_pkg::*;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] ones;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lab_logic_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();

  lab_logic_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each transfer against the scoreboard, and check
  // that a stalled result does not change.
  logic       held = 1'b0;
  logic [7:0] hx, hy;
  logic [3:0] ho;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else if (bus.out_valid) begin
      if (held) begin
        chk("hold_x", bus.x, hx);
        chk("hold_y", bus.y, hy);
        chk("hold_ones", bus.x_ones, ho);
      end
      if (bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got x=%0h want none at %0t", bus.x, $time);
        end else begin
          e = q.pop_front();
          chk("out_x", bus.x, e.x);
          chk("out_y", bus.y, e.y);
          chk("out_ones", bus.x_ones, e.ones);
        end
        held = 1'b0;
      end else begin
        held = 1'b1;
        hx = bus.x;
        hy = bus.y;
        ho = bus.x_ones;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [1:0] m, input logic [7:0] ex, input logic [7:0] ey,
                      input logic [3:0] eo);
    int n = 0;
    bus.a        = a;
    bus.b        = b;
    bus.c        = c;
    bus.mode     = mode_e'(m);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 want 1 at %0t", $time);
    end else begin
      q.push_back('{ex, ey, eo});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("drain_left", q.size(), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c         = '0;
    bus.mode      = MODE_GATE;
    bus.out_ready = 1'b1;
    bus.cnt_clr   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_ones", bus.x_ones, 0);
    chk("rst_count", bus.result_count, 0);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // GATE with latency and count checks
    tick();
    send(8'h0F, 8'h33, 8'h55, 2'b00, 8'h95, 8'h03, 4'd4);
    @(negedge clk);
    chk("lat_cycle1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", bus.out_valid, 1);
    chk("count_before_xfer", bus.result_count, 0);
    @(negedge clk);
    chk("count_after_gate", bus.result_count, 1);

    // Back-to-back SUM, PASS, ADD x2
    tick();
    send(8'hFF, 8'h01, 8'h00, 2'b01, 8'hFE, 8'h01, 4'd7);
    send(8'hA5, 8'h3C, 8'h00, 2'b11, 8'hA5, 8'h3C, 4'd4);
    send(8'hFF, 8'h01, 8'h01, 2'b10, 8'h01, 8'h01, 4'd1);
    send(8'h10, 8'h20, 8'hFE, 2'b10, 8'h30, 8'h00, 4'd2);
    drain();

    // Backpressure: two beats fill the pipe, the third is refused
    bus.out_ready = 1'b0;
    send(8'h01, 8'h02, 8'h03, 2'b11, 8'h01, 8'h02, 4'd1);
    send(8'hF0, 8'h0F, 8'h00, 2'b00, 8'h00, 8'h00, 4'd0);
    bus.a        = 8'h7F;
    bus.b        = 8'h01;
    bus.c        = 8'h00;
    bus.mode     = MODE_ADD;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", bus.in_ready, 0);
      chk("full_out_valid", bus.out_valid, 1);
      chk("full_x", bus.x, 8'h01);
    end
    tick();
    bus.out_ready = 1'b1;
    send(8'h7F, 8'h01, 8'h00, 2'b10, 8'h80, 8'h00, 4'd1);
    drain();

    // Counter saturation
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    @(negedge clk);
    chk("count_cleared", bus.result_count, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] v;
      v = 8'(i);
      send(v, ~v, 8'h00, 2'b11, v, ~v, 4'($countones(v)));
    end
    drain();
    @(negedge clk);
    chk("count_saturated", bus.result_count, 15);

    // Clear coincident with a transfer wins
    tick();
    send(8'h55, 8'hAA, 8'h00, 2'b11, 8'h55, 8'hAA, 4'd4);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("clr_wait_valid", bus.out_valid, 1);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_beats_xfer", bus.result_count, 0);
    tick();
    send(8'h0F, 8'h33, 8'h55, 2'b00, 8'h95, 8'h03, 4'd4);
    drain();
    @(negedge clk);
    chk("count_one_again", bus.result_count, 1);

    // Reset mid-flight with two beats stalled in the pipe
    tick();
    bus.out_ready = 1'b0;
    send(8'h11, 8'h22, 8'h00, 2'b11, 8'h11, 8'h22, 4'd2);
    send(8'h33, 8'h44, 8'h00, 2'b11, 8'h33, 8'h44, 4'd4);
    rst          = 1'b1;
    bus.a        = 8'hEE;
    bus.b        = 8'hEE;
    bus.mode     = MODE_PASS;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 0);
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_x", bus.x, 0);
    chk("midrst_y", bus.y, 0);
    chk("midrst_ones", bus.x_ones, 0);
    chk("midrst_count", bus.result_count, 0);
    tick();
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(8'hA5, 8'h3C, 8'h00, 2'b11, 8'hA5, 8'h3C, 4'd4);
    drain();
    @(negedge clk);
    chk("count_after_midrst", bus.result_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
